kbd_text_writer: RTL



---
 rtl/kbd_pkg.sv | 30 +++
 rtl/scan2ascii.sv | 77 +++++++
 rtl/kbd_text_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants and types for the keyboard text writer
// Purpose: PS/2 set-2 scan code constants, ASCII control codes, fetch FSM
//          state encoding and a Shift-key classifier.
// Ports:   none (package).
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_GAP,
    ST_PARSE
  } fetch_state_e;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/scan2ascii.sv
// rtl/scan2ascii.sv - combinational PS/2 set-2 scan code to ASCII translation
// Purpose: maps letters, digits, US punctuation, space, Enter and Backspace
//          to ASCII, honouring Shift; any other code maps to 0.
// Ports:   code_i  - scan code byte
//          shift_i - either Shift key is down
//          ascii_o - translated character, 0 if unmapped
module scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);

  // Upper byte: unshifted character, lower byte: shifted character.
  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (code_i)
      8'h1C: pair = {"a", "A"};
      8'h32: pair = {"b", "B"};
      8'h21: pair = {"c", "C"};
      8'h23: pair = {"d", "D"};
      8'h24: pair = {"e", "E"};
      8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};
      8'h33: pair = {"h", "H"};
      8'h43: pair = {"i", "I"};
      8'h3B: pair = {"j", "J"};
      8'h42: pair = {"k", "K"};
      8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};
      8'h31: pair = {"n", "N"};
      8'h44: pair = {"o", "O"};
      8'h4D: pair = {"p", "P"};
      8'h15: pair = {"q", "Q"};
      8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};
      8'h2C: pair = {"t", "T"};
      8'h3C: pair = {"u", "U"};
      8'h2A: pair = {"v", "V"};
      8'h1D: pair = {"w", "W"};
      8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};
      8'h1A: pair = {"z", "Z"};
      8'h16: pair = {"1", "!"};
      8'h1E: pair = {"2", "@"};
      8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};
      8'h2E: pair = {"5", "%"};
      8'h36: pair = {"6", "^"};
      8'h3D: pair = {"7", "&"};
      8'h3E: pair = {"8", "*"};
      8'h46: pair = {"9", "("};
      8'h45: pair = {"0", ")"};
      8'h0E: pair = {8'h60, "~"};
      8'h4E: pair = {"-", "_"};
      8'h55: pair = {"=", "+"};
      8'h54: pair = {"[", "{"};
      8'h5B: pair = {"]", "}"};
      8'h5D: pair = {"\\", "|"};
      8'h4C: pair = {";", ":"};
      8'h52: pair = {"'", "\""};
      8'h41: pair = {",", "<"};
      8'h49: pair = {".", ">"};
      8'h4A: pair = {"/", "?"};
      SC_SPACE: pair = {ASCII_SP, ASCII_SP};
      SC_ENTER: pair = {ASCII_CR, ASCII_CR};
      SC_BKSP:  pair = {ASCII_BS, ASCII_BS};
      default:  pair = 16'h0000;
    endcase
  end

  assign ascii_o = shift_i ? pair[7:0] : pair[15:8];

endmodule

// File: rtl/kbd_text_writer.sv
// rtl/kbd_text_writer.sv - PS/2 scan code parser and text buffer writer
// Purpose: pops scan codes from the ps2_keyboard FIFO, parses make/break/
//          extended sequences, tracks Shift and held key, counts presses and
//          writes printable characters into a COLS x ROWS text buffer.
// Ports:   clk, resetn           - clock, async active-low reset
//          ps2_data/ready/overflow, ps2_nextdata_n - FIFO handshake
//          txt_we/addr/char      - text buffer write port
//          cur_col/cur_row       - cursor position
//          last_scan/last_ascii  - last counted press
//          key_held/shift/key_count/err_ovf - status
module kbd_text_writer
  import kbd_pkg::*;
#(
  parameter int COLS          = 70,
  parameter int ROWS          = 30,
  parameter int CNT_W         = 8,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_ready,
  input  logic                          ps2_overflow,
  output logic                          ps2_nextdata_n,
  output logic                          txt_we,
  output logic [$clog2(COLS*ROWS)-1:0]  txt_addr,
  output logic [7:0]                    txt_char,
  output logic [$clog2(COLS)-1:0]       cur_col,
  output logic [$clog2(ROWS)-1:0]       cur_row,
  output logic [7:0]                    last_scan,
  output logic [7:0]                    last_ascii,
  output logic                          key_held,
  output logic                          shift,
  output logic [CNT_W-1:0]              key_count,
  output logic                          err_ovf
);

  localparam int ADDR_W = $clog2(COLS*ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS-1);

  fetch_state_e       state_q;
  logic [7:0]         code_q;
  logic               brk_q;
  logic               ext_q;
  logic [7:0]         held_code_q;
  logic               held_ext_q;
  logic               shift_q;
  logic               key_held_q;
  logic               nextdata_n_q;
  logic               txt_we_q;
  logic [ADDR_W-1:0]  txt_addr_q;
  logic [7:0]         txt_char_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [7:0]         last_scan_q;
  logic [7:0]         last_ascii_q;
  logic [CNT_W-1:0]   key_count_q;
  logic               err_ovf_q;

  logic [7:0]         map_ascii;
  logic [7:0]         press_ascii;
  logic               is_repeat;
  logic               is_print;
  logic [ROW_W-1:0]   nl_row;
  logic [COL_W-1:0]   adv_col;
  logic [ROW_W-1:0]   adv_row;
  logic [COL_W-1:0]   bs_col;
  logic [ROW_W-1:0]   bs_row;
  logic               at_origin;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  bs_addr;

  function automatic logic [ADDR_W-1:0] to_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  scan2ascii u_map (
    .code_i  (code_q),
    .shift_i (shift_q),
    .ascii_o (map_ascii)
  );

  always_comb begin
    // Extended keys (arrows, keypad Enter, ...) never produce text.
    press_ascii = ext_q ? 8'h00 : map_ascii;
    is_print    = (press_ascii >= 8'h20) && (press_ascii <= 8'h7E);
    // A typematic repeat is the same key, same prefix, while still held.
    is_repeat   = (REPEAT_FILTER != 0) && key_held_q &&
                  (code_q == held_code_q) && (ext_q == held_ext_q);

    nl_row  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    adv_col = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    adv_row = (col_q == COL_LAST) ? nl_row : row_q;

    at_origin = (col_q == '0) && (row_q == '0);
    if (col_q != '0) begin
      bs_col = col_q - COL_W'(1);
      bs_row = row_q;
    end else begin
      bs_col = COL_LAST;
      bs_row = row_q - ROW_W'(1);
    end

    cur_addr = to_addr(row_q, col_q);
    bs_addr  = to_addr(bs_row, bs_col);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      shift_q      <= 1'b0;
      key_held_q   <= 1'b0;
      nextdata_n_q <= 1'b1;
      txt_we_q     <= 1'b0;
      txt_addr_q   <= '0;
      txt_char_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      last_scan_q  <= '0;
      last_ascii_q <= '0;
      key_count_q  <= '0;
      err_ovf_q    <= 1'b0;
    end else begin
      txt_we_q <= 1'b0;
      if (ps2_overflow) err_ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (ps2_ready) begin
            code_q       <= ps2_data;
            nextdata_n_q <= 1'b0;
            state_q      <= ST_POP;
          end
        end
        ST_POP: begin
          nextdata_n_q <= 1'b1;
          state_q      <= ST_GAP;
        end
        // The FIFO's ready flag may still reflect the popped byte here.
        ST_GAP: state_q <= ST_PARSE;
        ST_PARSE: begin
          state_q <= ST_IDLE;
          if (code_q == SC_EXT) begin
            ext_q <= 1'b1;
          end else if (code_q == SC_BRK) begin
            brk_q <= 1'b1;
          end else if (brk_q) begin
            if (is_shift(code_q)) shift_q <= 1'b0;
            if (code_q == held_code_q) key_held_q <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
          end else begin
            ext_q <= 1'b0;
            if (is_shift(code_q)) begin
              shift_q <= 1'b1;
            end else if (!is_repeat) begin
              key_held_q   <= 1'b1;
              held_code_q  <= code_q;
              held_ext_q   <= ext_q;
              last_scan_q  <= code_q;
              last_ascii_q <= press_ascii;
              key_count_q  <= key_count_q + CNT_W'(1);
              if (is_print) begin
                txt_we_q   <= 1'b1;
                txt_addr_q <= cur_addr;
                txt_char_q <= press_ascii;
                col_q      <= adv_col;
                row_q      <= adv_row;
              end else if (press_ascii == ASCII_CR) begin
                col_q <= '0;
                row_q <= nl_row;
              end else if ((press_ascii == ASCII_BS) && !at_origin) begin
                txt_we_q   <= 1'b1;
                txt_addr_q <= bs_addr;
                txt_char_q <= ASCII_SP;
                col_q      <= bs_col;
                row_q      <= bs_row;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign txt_we         = txt_we_q;
  assign txt_addr       = txt_addr_q;
  assign txt_char       = txt_char_q;
  assign cur_col        = col_q;
  assign cur_row        = row_q;
  assign last_scan      = last_scan_q;
  assign last_ascii     = last_ascii_q;
  assign key_held       = key_held_q;
  assign shift          = shift_q;
  assign key_count      = key_count_q;
  assign err_ovf        = err_ovf_q;

endmodule
